// File: rtl/i2c_wb_pkg.sv
// Shared types and constants for the I2C target with Wishbone register port.
// Holds the FSM encoding, register offsets and STAT bit positions.
package i2c_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [1:0] REG_ADR  = 2'd0;
    localparam logic [1:0] REG_TXD  = 2'd1;
    localparam logic [1:0] REG_RXD  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam int STAT_RXV  = 0;
    localparam int STAT_TXE  = 1;
    localparam int STAT_BUSY = 2;
    localparam int STAT_SEL  = 3;
    localparam int STAT_DIR  = 4;
    localparam int STAT_NACK = 5;
    localparam int STAT_IE   = 6;
    localparam int STAT_IRQ  = 7;

endpackage

// File: rtl/i2c_wb_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line plus edge detection.
// Resets to 1 so an idle (released) line produces no edge after reset.
module i2c_wb_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= 3'b111;
        else        sr <= {sr[1:0], d};
    end

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/i2c_wb_target.sv
// I2C target device with a four-register Wishbone slave port.
// Bytes written by the controller land in RXD; bytes it reads come from TXD.
module i2c_wb_target
    import i2c_wb_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] DEFAULT_ADDR = 7'h22
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    output logic                     ack_o,
    output logic                     irq,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     scl_o,
    output logic                     sda_o
);

    localparam int DW = I2C_DATA_WIDTH;
    localparam int AW = I2C_ADDR_WIDTH;

    logic scl_q, scl_rise, scl_fall;
    logic sda_q, sda_rise, sda_fall;

    i2c_wb_sync_edge u_scl (
        .clk   (clk_i),
        .rst_n (rst_i),
        .d     (scl_i),
        .q     (scl_q),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_wb_sync_edge u_sda (
        .clk   (clk_i),
        .rst_n (rst_i),
        .d     (sda_i),
        .q     (sda_q),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start, stop;
    assign start = sda_fall & scl_q;
    assign stop  = sda_rise & scl_q;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [DW-1:0] sh, sh_n;
    logic          drv, drv_n;
    logic          phase, phase_n;
    logic          pend, pend_n;
    logic          set_sel, set_rx, set_nack, tx_take, due;

    logic [AW-1:0] own;
    logic          en;
    logic [DW-1:0] txd, rxd;
    logic          tx_empty, rx_valid, nacked, ie;
    logic          busy, selected, dir;
    logic          active, rd_stretch;

    assign active = (state != ST_IDLE) && (state != ST_ADDR)
                 && (state != ST_IGNORE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sh    <= '0;
            drv   <= 1'b0;
            phase <= 1'b0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            drv   <= drv_n;
            phase <= phase_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sh_n     = sh;
        drv_n    = drv;
        phase_n  = phase;
        pend_n   = pend;
        set_sel  = 1'b0;
        set_rx   = 1'b0;
        set_nack = 1'b0;
        tx_take  = 1'b0;
        due      = 1'b0;
        if (stop) begin
            state_n = ST_IDLE;
            drv_n   = 1'b0;
            pend_n  = 1'b0;
        end else if (start) begin
            state_n = ST_ADDR;
            cnt_n   = '0;
            drv_n   = 1'b0;
            pend_n  = 1'b0;
        end else if (!en && active) begin
            state_n = ST_IGNORE;
            drv_n   = 1'b0;
            pend_n  = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_n  = {sh[DW-2:0], sda_q};
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'(DW - 1)) begin
                            if (en && sh[AW-1:0] == own) begin
                                set_sel = 1'b1;
                                state_n = ST_ADDR_ACK;
                                phase_n = 1'b0;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            drv_n   = 1'b1;
                            phase_n = 1'b1;
                        end else begin
                            drv_n = 1'b0;
                            cnt_n = '0;
                            if (dir) begin
                                state_n = ST_RD_BYTE;
                                due     = 1'b1;
                            end else begin
                                state_n = ST_WR_BYTE;
                            end
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        sh_n  = {sh[DW-2:0], sda_q};
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'(DW - 1)) begin
                            state_n = ST_WR_ACK;
                            phase_n = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    // A previous byte still unread holds SCL low until RXD is read
                    if (!phase && pend && !rx_valid) begin
                        set_rx  = 1'b1;
                        drv_n   = 1'b1;
                        phase_n = 1'b1;
                        pend_n  = 1'b0;
                    end else if (!phase && !pend && scl_fall) begin
                        if (rx_valid) begin
                            pend_n = 1'b1;
                        end else begin
                            set_rx  = 1'b1;
                            drv_n   = 1'b1;
                            phase_n = 1'b1;
                        end
                    end else if (phase && scl_fall) begin
                        drv_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (!pend) begin
                        if (scl_rise) begin
                            cnt_n = cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt == 4'(DW)) begin
                                state_n = ST_RD_ACK;
                                drv_n   = 1'b0;
                                phase_n = 1'b0;
                            end else begin
                                drv_n = ~sh[DW-1];
                                sh_n  = {sh[DW-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && !phase) begin
                        if (!sda_q) begin
                            phase_n = 1'b1;
                        end else begin
                            set_nack = 1'b1;
                            state_n  = ST_IGNORE;
                        end
                    end else if (scl_fall && phase) begin
                        state_n = ST_RD_BYTE;
                        due     = 1'b1;
                    end
                end
                default: ;
            endcase
            // First bit of a read byte: load TXD, or stretch while it is empty
            if (due || (state == ST_RD_BYTE && pend)) begin
                if (!tx_empty) begin
                    sh_n    = {txd[DW-2:0], 1'b0};
                    drv_n   = ~txd[DW-1];
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                    tx_take = 1'b1;
                end else begin
                    pend_n = 1'b1;
                end
            end
        end
    end

    logic                     wb_acc;
    logic [1:0]               adr;
    logic [7:0]               stat;
    logic [WB_DATA_WIDTH-1:0] rd_mux;

    assign wb_acc = cyc_i & stb_i & ~ack_o;
    assign adr    = adr_i[1:0];

    always_comb begin
        stat            = '0;
        stat[STAT_RXV]  = rx_valid;
        stat[STAT_TXE]  = tx_empty;
        stat[STAT_BUSY] = busy;
        stat[STAT_SEL]  = selected;
        stat[STAT_DIR]  = dir;
        stat[STAT_NACK] = nacked;
        stat[STAT_IE]   = ie;
        stat[STAT_IRQ]  = irq;
    end

    always_comb begin
        rd_mux = '0;
        unique case (adr)
            REG_ADR:  rd_mux = {en, own};
            REG_TXD:  rd_mux = txd;
            REG_RXD:  rd_mux = rxd;
            REG_STAT: rd_mux = stat;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o    <= 1'b0;
            dat_o    <= '0;
            own      <= DEFAULT_ADDR;
            en       <= 1'b0;
            txd      <= '0;
            tx_empty <= 1'b1;
            rxd      <= '0;
            rx_valid <= 1'b0;
            nacked   <= 1'b0;
            ie       <= 1'b0;
            busy     <= 1'b0;
            selected <= 1'b0;
            dir      <= 1'b0;
        end else begin
            ack_o <= wb_acc;
            dat_o <= '0;
            if (wb_acc && we_i) begin
                unique case (adr)
                    REG_ADR: {en, own} <= dat_i;
                    REG_TXD: begin
                        txd      <= dat_i;
                        tx_empty <= 1'b0;
                    end
                    REG_STAT: begin
                        if (dat_i[STAT_NACK]) nacked <= 1'b0;
                        ie <= dat_i[STAT_IE];
                    end
                    default: ;
                endcase
            end
            if (wb_acc && !we_i) begin
                dat_o <= rd_mux;
                if (adr == REG_RXD) rx_valid <= 1'b0;
            end
            // Flag sets come last so they win over a same-cycle clear
            if (tx_take) tx_empty <= 1'b1;
            if (set_rx) begin
                rx_valid <= 1'b1;
                rxd      <= sh;
            end
            if (set_nack) nacked <= 1'b1;
            if (start)     busy <= 1'b1;
            else if (stop) busy <= 1'b0;
            if (start || stop) begin
                selected <= 1'b0;
            end else if (set_sel) begin
                selected <= 1'b1;
                dir      <= sda_q;
            end
        end
    end

    assign rd_stretch = pend && (state == ST_RD_BYTE);
    assign irq   = ie & (rx_valid | nacked | rd_stretch);
    assign scl_o = ~(pend & en);
    assign sda_o = ~(drv & en);

endmodule

// File: tb/tb_i2c_wb_target.sv
// Directed bench: Wishbone register vectors plus an I2C controller model
// on a wired-AND bus exercising write, read, stretching and addressing.
module tb_i2c_wb_target;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cyc_i, stb_i, we_i;
    logic [1:0] adr_i;
    logic [7:0] dat_i, dat_o;
    logic       ack_o, irq, scl_o, sda_o;
    logic       scl_m, sda_m;
    logic       scl_bus, sda_bus;

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    i2c_wb_target dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .irq   (irq),
        .scl_i (scl_bus),
        .sda_i (sda_bus),
        .scl_o (scl_o),
        .sda_o (sda_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sda_low_cnt = 0;
    bit stuck = 0;

    always @(posedge clk) if (sda_o === 1'b0) sda_low_cnt <= sda_low_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic q_wait;
        tick(8);
    endtask

    task automatic scl_release;
        int n;
        scl_m = 1'b1;
        n = 0;
        while (!stuck && scl_bus !== 1'b1 && n < 4000) begin
            tick(1);
            n++;
        end
        if (n >= 4000) begin
            stuck = 1;
            tests++;
            fails++;
            $display("FAIL scl_timeout: got scl held low expected release");
        end
    endtask

    task automatic wb(input logic [1:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] r, output logic a1, output logic a2);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        @(posedge clk); #1;
        a1 = ack_o;
        r  = dat_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        a2 = ack_o;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        logic a1, a2;
        wb(a, 1'b1, d, r, a1, a2);
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] r);
        logic a1, a2;
        wb(a, 1'b0, 8'h00, r, a1, a2);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; q_wait;
        scl_release;  q_wait;
        sda_m = 1'b0; q_wait;
        scl_m = 1'b0; q_wait;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; q_wait;
        scl_release;  q_wait;
        sda_m = 1'b1; q_wait;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; q_wait;
        scl_release; q_wait; q_wait;
        scl_m = 1'b0; q_wait;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; q_wait;
        scl_release; q_wait;
        b = sda_bus; q_wait;
        scl_m = 1'b0; q_wait;
    endtask

    task automatic put_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        put_bits(d);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] adr;
        logic       we;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[14];

    initial begin
        logic [7:0] r;
        logic a, a1, a2;
        int c0;

        vt[0]  = '{"rst_adr",  2'd0, 1'b0, 8'h00, 8'h22};
        vt[1]  = '{"rst_stat", 2'd3, 1'b0, 8'h00, 8'h02};
        vt[2]  = '{"rst_rxd",  2'd2, 1'b0, 8'h00, 8'h00};
        vt[3]  = '{"w_adr",    2'd0, 1'b1, 8'hA2, 8'h00};
        vt[4]  = '{"adr_rw",   2'd0, 1'b0, 8'h00, 8'hA2};
        vt[5]  = '{"w_ie",     2'd3, 1'b1, 8'h40, 8'h00};
        vt[6]  = '{"stat_ie",  2'd3, 1'b0, 8'h00, 8'h42};
        vt[7]  = '{"w_txd",    2'd1, 1'b1, 8'h3C, 8'h00};
        vt[8]  = '{"txd_rb",   2'd1, 1'b0, 8'h00, 8'h3C};
        vt[9]  = '{"stat_txf", 2'd3, 1'b0, 8'h00, 8'h40};
        vt[10] = '{"w_rxd",    2'd2, 1'b1, 8'h99, 8'h00};
        vt[11] = '{"rxd_ro",   2'd2, 1'b0, 8'h00, 8'h00};
        vt[12] = '{"w_w1c",    2'd3, 1'b1, 8'h60, 8'h00};
        vt[13] = '{"stat_w1c", 2'd3, 1'b0, 8'h00, 8'h40};

        rst_i = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = 2'd0; dat_i = 8'h00;
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        check("rst_outs", {ack_o, irq, scl_o, sda_o}, 4'b0011);
        check("rst_dat", dat_o, 8'h00);
        @(negedge clk);
        rst_i = 1'b1;
        tick(2);

        for (int i = 0; i < 14; i++) begin
            wb(vt[i].adr, vt[i].we, vt[i].wdat, r, a1, a2);
            if (!vt[i].we) check(vt[i].name, r, vt[i].exp);
        end

        wb(2'd0, 1'b1, 8'hA2, r, a1, a2);
        check("ack_pulse", {a1, a2}, 2'b10);

        // controller write of one byte
        i2c_start;
        put_byte(8'h44, a);
        check("wr_addr_ack", a, 1'b0);
        put_byte(8'h5A, a);
        check("wr_data_ack", a, 1'b0);
        i2c_stop;
        check("wr_irq", irq, 1'b1);
        rd(2'd3, r);
        check("wr_stat", r & 8'h05, 8'h01);
        rd(2'd2, r);
        check("wr_rxd", r, 8'h5A);
        check("wr_irq_clr", irq, 1'b0);

        // second byte arrives while the first is unread
        i2c_start;
        put_byte(8'h44, a);
        check("b2b_addr_ack", a, 1'b0);
        put_byte(8'hAA, a);
        check("b2b_ack1", a, 1'b0);
        put_bits(8'h55);
        q_wait;
        check("b2b_stretch", scl_o, 1'b0);
        rd(2'd2, r);
        check("b2b_rxd1", r, 8'hAA);
        tick(4);
        check("b2b_release", scl_o, 1'b1);
        get_bit(a);
        check("b2b_ack2", a, 1'b0);
        i2c_stop;
        rd(2'd2, r);
        check("b2b_rxd2", r, 8'h55);

        // controller read with NACK
        wr(2'd1, 8'hC3);
        i2c_start;
        put_byte(8'h45, a);
        check("rd_addr_ack", a, 1'b0);
        get_byte(r);
        check("rd_data", r, 8'hC3);
        put_bit(1'b1);
        i2c_stop;
        rd(2'd3, r);
        check("rd_nack_txe", r & 8'h22, 8'h22);
        check("rd_nack_irq", irq, 1'b1);
        wr(2'd3, 8'h60);
        check("nack_w1c_irq", irq, 1'b0);

        // read with TXD empty stretches until loaded
        i2c_start;
        put_byte(8'h45, a);
        check("rs_addr_ack", a, 1'b0);
        q_wait;
        check("rs_stretch", scl_o, 1'b0);
        check("rs_irq", irq, 1'b1);
        wr(2'd1, 8'h81);
        tick(4);
        check("rs_release", scl_o, 1'b1);
        get_byte(r);
        check("rs_data", r, 8'h81);
        put_bit(1'b1);
        i2c_stop;
        wr(2'd3, 8'h60);

        // address mismatch
        c0 = sda_low_cnt;
        i2c_start;
        put_byte(8'h60, a);
        check("mis_nack", a, 1'b1);
        i2c_stop;
        check("mis_sda_idle", sda_low_cnt - c0, 0);

        // disabled, then repeated START after enabling
        wr(2'd0, 8'h22);
        i2c_start;
        put_byte(8'h44, a);
        check("dis_nack", a, 1'b1);
        wr(2'd0, 8'hA2);
        i2c_start;
        put_byte(8'h44, a);
        check("rstart_ack", a, 1'b0);
        rd(2'd3, r);
        check("busy_sel", r & 8'h0C, 8'h0C);
        i2c_stop;
        rd(2'd3, r);
        check("idle_stat", r & 8'h0C, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
